// File: rtl/nios_system_entity_tracker.sv
// Avalon-MM entity lifetime table: spawn/kill via writes, per-frame ageing on synchronised VSYNC.
// Optional expiry interrupt and IRQMASK register are enabled with `define ENTITY_TRACKER_IRQ_EN.
module nios_system_entity_tracker #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned LIFE_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        vsync_in,
    output logic        entity_active
`ifdef ENTITY_TRACKER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_SPAWN   = 3'd1;
    localparam logic [2:0] ADDR_KILL    = 3'd2;
    localparam logic [2:0] ADDR_EXPIRED = 3'd3;
    localparam logic [2:0] ADDR_FRAMES  = 3'd4;
    localparam int unsigned FRAME_W     = 16;
    localparam logic [LIFE_W-1:0] LIFE_PERM = '1;

    logic                 r_vs_meta;
    logic                 r_vs_sync;
    logic                 r_vs_prev;
    logic                 r_tick;
    logic [NUM_SLOTS-1:0] r_active;
    logic [NUM_SLOTS-1:0] r_expired;
    logic [LIFE_W-1:0]    r_life [NUM_SLOTS];
    logic [FRAME_W-1:0]   r_frames;

    logic [NUM_SLOTS-1:0] w_active_nxt;
    logic [NUM_SLOTS-1:0] w_expired_nxt;
    logic [LIFE_W-1:0]    w_life_nxt [NUM_SLOTS];
    logic [31:0]          w_rdata;
    logic                 w_wr_spawn;
    logic                 w_wr_kill;
    logic                 w_wr_expired;
    logic [2:0]           w_spawn_slot;
    logic [LIFE_W-1:0]    w_spawn_life;
    logic [NUM_SLOTS-1:0] w_slot_mask;
    logic                 w_unused;

    assign w_wr_spawn   = write && (address == ADDR_SPAWN);
    assign w_wr_kill    = write && (address == ADDR_KILL);
    assign w_wr_expired = write && (address == ADDR_EXPIRED);
    assign w_spawn_slot = writedata[10:8];
    assign w_spawn_life = writedata[LIFE_W-1:0];
    assign w_slot_mask  = writedata[NUM_SLOTS-1:0];
    assign w_unused     = ^{read, writedata};

    // VSYNC synchroniser, edge detect and registered one-cycle tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vs_meta <= vsync_in;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            r_tick    <= r_vs_sync & ~r_vs_prev;
        end
    end

    // Slot update: spawn beats kill/ageing, kill beats expiry, new expiry beats W1C
    always_comb begin
        w_active_nxt  = r_active;
        w_expired_nxt = r_expired & ~(w_wr_expired ? w_slot_mask : '0);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_life_nxt[i] = r_life[i];
            if (w_wr_spawn && (w_spawn_slot == 3'(i))) begin
                if (w_spawn_life != '0) begin
                    w_active_nxt[i] = 1'b1;
                    w_life_nxt[i]   = w_spawn_life;
                end else begin
                    w_active_nxt[i] = 1'b0;
                end
            end else if (w_wr_kill && w_slot_mask[i]) begin
                w_active_nxt[i] = 1'b0;
            end else if (r_tick && r_active[i] && (r_life[i] != LIFE_PERM)) begin
                if (r_life[i] > LIFE_W'(1)) begin
                    w_life_nxt[i] = r_life[i] - LIFE_W'(1);
                end else begin
                    w_active_nxt[i]  = 1'b0;
                    w_life_nxt[i]    = '0;
                    w_expired_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active      <= '0;
            r_expired     <= '0;
            r_frames      <= '0;
            entity_active <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_life[i] <= '0;
            end
        end else begin
            r_active      <= w_active_nxt;
            r_expired     <= w_expired_nxt;
            entity_active <= |r_active;
            if (r_tick) begin
                r_frames <= r_frames + FRAME_W'(1);
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_life[i] <= w_life_nxt[i];
            end
        end
    end

`ifdef ENTITY_TRACKER_IRQ_EN
    localparam logic [2:0] ADDR_IRQMASK = 3'd6;
    logic [NUM_SLOTS-1:0] r_irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            irq        <= 1'b0;
        end else begin
            if (write && (address == ADDR_IRQMASK)) begin
                r_irq_mask <= w_slot_mask;
            end
            irq <= |(r_expired & r_irq_mask);
        end
    end
`endif

    // Read mux, registered every cycle
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS:  w_rdata = 32'(r_active);
            ADDR_EXPIRED: w_rdata = 32'(r_expired);
            ADDR_FRAMES:  w_rdata = 32'(r_frames);
`ifdef ENTITY_TRACKER_IRQ_EN
            ADDR_IRQMASK: w_rdata = 32'(r_irq_mask);
`endif
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_nios_system_entity_tracker.sv
// Directed bench for nios_system_entity_tracker: register map, ageing, priorities and optional irq.
module tb_nios_system_entity_tracker;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        vsync_in;
    logic        entity_active;
`ifdef ENTITY_TRACKER_IRQ_EN
    logic        irq;
`endif

    int vectors;
    int miscompares;
    int exp_frames;

    nios_system_entity_tracker #(.NUM_SLOTS(4), .LIFE_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .read          (read),
        .readdata      (readdata),
        .vsync_in      (vsync_in),
        .entity_active (entity_active)
`ifdef ENTITY_TRACKER_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        reset_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0; vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_frames = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); address = a; writedata = d; write = 1'b1;
        @(negedge clk); write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] q);
        @(negedge clk); address = a; read = 1'b1;
        @(negedge clk); read = 1'b0; q = readdata;
    endtask

    // One VSYNC pulse; optional write lands on the edge where ageing is applied
    task automatic vsync_pulse(input logic wr_en, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        if (wr_en) begin address = a; writedata = d; write = 1'b1; end
        @(negedge clk); write = 1'b0; vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        exp_frames++;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0; vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (entity_active !== 1'b0 || readdata !== 32'h0) begin
            $display("FAIL reset_outputs ea=%b rd=%h exp 0/0", entity_active, readdata); miscompares++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        exp_frames = 0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), q);
            vectors++;
            if (q !== 32'h0) begin
                $display("FAIL reset_read addr=%0d got %h exp 0", a, q); miscompares++;
            end
        end
        vsync_pulse(1'b0, 3'd0, 32'h0);
        rd(3'd4, q);
        vectors++;
        if (q !== 32'h1) begin $display("FAIL frames_one got %h exp 1", q); miscompares++; end
    endtask

    task automatic test_expiry();
        logic [31:0] q;
        wr(3'd1, 32'h0000_0203);
        vectors++;
        if (entity_active !== 1'b0) begin $display("FAIL ea_spawn_lag got %b exp 0", entity_active); miscompares++; end
        @(negedge clk);
        vectors++;
        if (entity_active !== 1'b1) begin $display("FAIL ea_spawn got %b exp 1", entity_active); miscompares++; end
        for (int k = 0; k < 2; k++) begin
            vsync_pulse(1'b0, 3'd0, 32'h0);
            rd(3'd0, q);
            vectors++;
            if (q !== 32'h4) begin $display("FAIL status_aging tick=%0d got %h exp 4", k + 1, q); miscompares++; end
        end
        @(negedge clk); vsync_in = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (entity_active !== 1'b1) begin $display("FAIL ea_expiry_lag got %b exp 1", entity_active); miscompares++; end
        @(negedge clk);
        vectors++;
        if (entity_active !== 1'b0) begin $display("FAIL ea_expiry got %b exp 0", entity_active); miscompares++; end
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        exp_frames++;
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL status_expired got %h exp 0", q); miscompares++; end
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h4) begin $display("FAIL expired_slot2 got %h exp 4", q); miscompares++; end
        rd(3'd4, q);
        vectors++;
        if (q !== 32'(exp_frames)) begin $display("FAIL frames_count got %h exp %h", q, 32'(exp_frames)); miscompares++; end
        wr(3'd3, 32'h4);
    endtask

    task automatic test_permanent();
        logic [31:0] q;
        apply_reset();
        wr(3'd1, 32'h0000_00FF);
        for (int k = 0; k < 300; k++) vsync_pulse(1'b0, 3'd0, 32'h0);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h1) begin $display("FAIL perm_status got %h exp 1", q); miscompares++; end
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL perm_expired got %h exp 0", q); miscompares++; end
        rd(3'd4, q);
        vectors++;
        if (q !== 32'd300) begin $display("FAIL perm_frames got %0d exp 300", q); miscompares++; end
        wr(3'd2, 32'h1);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL kill_status got %h exp 0", q); miscompares++; end
    endtask

    task automatic test_tick_priority();
        logic [31:0] q;
        wr(3'd1, 32'h0000_0101);
        vsync_pulse(1'b1, 3'd2, 32'h2);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL kill_vs_tick_status got %h exp 0", q); miscompares++; end
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL kill_vs_tick_expired got %h exp 0", q); miscompares++; end
        wr(3'd1, 32'h0000_0101);
        vsync_pulse(1'b1, 3'd1, 32'h0000_0105);
        for (int k = 0; k < 4; k++) vsync_pulse(1'b0, 3'd0, 32'h0);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h2) begin $display("FAIL spawn_vs_tick_alive got %h exp 2", q); miscompares++; end
        vsync_pulse(1'b0, 3'd0, 32'h0);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL spawn_vs_tick_dead got %h exp 0", q); miscompares++; end
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h2) begin $display("FAIL spawn_vs_tick_expired got %h exp 2", q); miscompares++; end
        wr(3'd3, 32'h2);
    endtask

    task automatic test_w1c_vs_expiry();
        logic [31:0] q;
        wr(3'd1, 32'h0000_0301);
        vsync_pulse(1'b1, 3'd3, 32'h8);
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h8) begin $display("FAIL expiry_beats_w1c got %h exp 8", q); miscompares++; end
        wr(3'd3, 32'h8);
        rd(3'd3, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL w1c_clear got %h exp 0", q); miscompares++; end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] q;
        wr(3'd1, 32'h0000_050A);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL spawn_bad_slot got %h exp 0", q); miscompares++; end
        wr(3'd1, 32'h0000_0005);
        wr(3'd1, 32'h0000_0000);
        rd(3'd0, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL spawn_zero_clears got %h exp 0", q); miscompares++; end
        wr(3'd4, 32'h0000_1234);
        rd(3'd4, q);
        vectors++;
        if (q !== 32'(exp_frames)) begin $display("FAIL frames_ro got %h exp %h", q, 32'(exp_frames)); miscompares++; end
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL addr7_zero got %h exp 0", q); miscompares++; end
`ifndef ENTITY_TRACKER_IRQ_EN
        wr(3'd6, 32'hF);
        rd(3'd6, q);
        vectors++;
        if (q !== 32'h0) begin $display("FAIL addr6_zero got %h exp 0", q); miscompares++; end
`endif
    endtask

`ifdef ENTITY_TRACKER_IRQ_EN
    task automatic test_irq();
        logic [31:0] q;
        apply_reset();
        wr(3'd6, 32'h1);
        rd(3'd6, q);
        vectors++;
        if (q !== 32'h1) begin $display("FAIL irqmask_rd got %h exp 1", q); miscompares++; end
        wr(3'd1, 32'h0000_0002);
        vsync_pulse(1'b0, 3'd0, 32'h0);
        @(negedge clk); vsync_in = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin $display("FAIL irq_lag got %b exp 0", irq); miscompares++; end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin $display("FAIL irq_set got %b exp 1", irq); miscompares++; end
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        wr(3'd3, 32'h1);
        vectors++;
        if (irq !== 1'b1) begin $display("FAIL irq_clear_lag got %b exp 1", irq); miscompares++; end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin $display("FAIL irq_clear got %b exp 0", irq); miscompares++; end
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0; exp_frames = 0;
        test_reset();
        test_expiry();
        test_permanent();
        test_tick_priority();
        test_w1c_vs_expiry();
        test_ignored_writes();
`ifdef ENTITY_TRACKER_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nios_system_entity_tracker.md
# nios_system_entity_tracker

Avalon-MM slave that owns the game's entity lifetime table and produces the single-bit `entity_active` signal consumed by the `entity_active` PIO input port. The NIOS spawns and kills entities through register writes. The block ages every live entity once per video frame, using a synchronised VSYNC edge. `entity_active` is the registered OR of all live slots, so software can poll one PIO bit to learn whether anything is still on screen.

## Interface
- `NUM_SLOTS`, 4: number of entity slots; legal range 1..8.
- `LIFE_W`, 8: lifetime counter width in frames; all-ones value means permanent.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 3: register select.
- `write` input 1: Avalon write strobe.
- `writedata` input 32: write data.
- `read` input 1: Avalon read strobe (informational; readdata is updated every cycle).
- `readdata` output 32: registered read data.
- `vsync_in` input 1: raw VSYNC from the VGA controller, asynchronous to `clk`; it is synchronised internally.
- `entity_active` output 1: high while any slot is live; drives the PIO `in_port`.
- `irq` output 1: expiry interrupt; present only with `ENTITY_TRACKER_IRQ_EN`.

## Operation
- Per slot i, the block keeps two pieces of state:
  - `active[i]`: 1 bit.
  - `life[i]`: `LIFE_W` bits.
- Register map (address → function):
  - 0 STATUS, read-only: bits[NUM_SLOTS-1:0] = `active`; the remaining bits read 0.
  - 1 SPAWN, write-only: slot = `writedata[10:8]`, lifetime = `writedata[LIFE_W-1:0]`.
    - Lifetime ≠ 0: set `active[slot]` and load `life[slot]` = lifetime.
    - Lifetime = 0: clear `active[slot]`.
    - Slot ≥ `NUM_SLOTS`: the write is ignored.
  - 2 KILL, write-only: every slot whose bit is set in `writedata[NUM_SLOTS-1:0]` is cleared.
  - 3 EXPIRED: sticky per-slot bits set on natural expiry. Writing 1 to a bit clears it.
  - 4 FRAMES: 16-bit frame counter in bits[15:0]. It increments on every tick and wraps 0xFFFF→0. Writes are ignored.
  - 5–7: read 0; writes are ignored.
- VSYNC path:
  - 2-flop synchroniser, then a third flop for edge detection.
  - `tick` is a one-cycle pulse on the synchronised rising edge.
- On `tick`, each slot with `active[i]` = 1 is aged:
  - `life[i]` = all-ones: no change (permanent).
  - `life[i]` > 1: decrement.
  - `life[i]` = 1: clear `active[i]`, set `life[i]` to 0, set `EXPIRED[i]`.
- Priority when events hit the same slot in the same cycle:
  - SPAWN write beats tick ageing: the slot is loaded with the written value, not decremented.
  - KILL beats tick expiry: the slot is cleared and `EXPIRED` is not set.
  - A new expiry beats a W1C clear of the same `EXPIRED` bit: the bit stays 1.
- `entity_active` is a register updated each cycle with |`active` as it was before that edge.
- Reset values:
  - `active`, `life`, `EXPIRED`, FRAMES, synchroniser flops: 0.
  - `readdata` = 0, `entity_active` = 0, `irq` = 0.

## Timing
- Writes take effect at the clock edge where `write` is sampled high; there are no wait states.
- `readdata` is registered: the value for `address` sampled at edge N appears after edge N.
- Reads never have side effects.
- Tick latency: `vsync_in` sampled high at edge N gives `tick` high during the cycle after edge N+2. Ageing is applied at edge N+3.
- `entity_active` lags a change of `active` by one edge, for example:
  - SPAWN at edge N, then `entity_active` = 1 after edge N+1.
  - Last expiry at edge M, then `entity_active` = 0 after edge M+1.
- `vsync_in` must stay high for at least 2 `clk` periods and low for at least 2 `clk` periods to be recognised. Shorter pulses may be missed.
- Asserting `reset_n` mid-frame clears all state immediately, independent of `clk`. After release, the first tick requires a fresh synchronised rising edge.

## Configuration
- Macro: `ENTITY_TRACKER_IRQ_EN`.
- Defined:
  - Add address 6 IRQMASK, read/write, bits[NUM_SLOTS-1:0], reset 0.
  - Add `irq` as a registered output: `irq` = |(`EXPIRED` & IRQMASK), asserted one edge after the condition becomes true.
  - The interrupt is cleared by W1C to EXPIRED or by clearing the mask bit.
- Undefined: there is no `irq` port, and address 6 reads 0 and ignores writes.

## Test plan
- Reset, then read each address → readdata = 0 and `entity_active` = 0. Toggle `vsync_in` once → FRAMES = 1.
- SPAWN slot 2 with lifetime 3, then send 3 VSYNC pulses:
  - STATUS = 0x4 until the 3rd tick, then 0.
  - EXPIRED = 0x4.
  - `entity_active` falls one edge after `active[2]` clears.
- SPAWN slot 0 with lifetime 0xFF, then send 300 VSYNC pulses → STATUS stays 0x1, EXPIRED = 0, FRAMES = 300.
- SPAWN slot 1 with lifetime 1, and write KILL 0x2 in the exact cycle `tick` is high → STATUS = 0, EXPIRED = 0.
  - Repeat with a SPAWN of lifetime 5 in the tick cycle → `life[1]` = 5 and no decrement.
- Drive slot 3 to expiry while writing EXPIRED W1C 0x8 in the same cycle → EXPIRED = 0x8. Then write 0x8 again → EXPIRED = 0.
- With `ENTITY_TRACKER_IRQ_EN`:
  - IRQMASK = 0x1, slot 0 lifetime 2, two ticks → `irq` = 1 one edge after EXPIRED[0] sets.
  - W1C EXPIRED → `irq` = 0 on the next edge.
